// File: rtl/dual_grant_arbiter_if.sv
// rtl/dual_grant_arbiter_if.sv - request/ack/grant bundle between requesters and the dual grant arbiter
//
// Purpose: groups the request vector, the two slot acks and the grant-side
// outputs of dual_grant_arbiter into one bundle.
// Signals:
//   req        N   request vector, requester i holds req[i] until acked
//   ack1/ack2  1   slot grant consumed this cycle
//   gnt*_idx   IW  index held by each slot
//   gnt*_valid 1   slot holds a grant
//   gnt_onehot N   one-hot OR of both valid grants
//   busy_cnt   2   number of valid slots
// Modports: master = requester/consumer side, slave = arbiter side.
interface dual_grant_arbiter_if #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
);
    logic [N-1:0]  req;
    logic          ack1;
    logic          ack2;
    logic [IW-1:0] gnt1_idx;
    logic          gnt1_valid;
    logic [IW-1:0] gnt2_idx;
    logic          gnt2_valid;
    logic [N-1:0]  gnt_onehot;
    logic [1:0]    busy_cnt;

    modport master (
        output req, ack1, ack2,
        input  gnt1_idx, gnt1_valid, gnt2_idx, gnt2_valid, gnt_onehot, busy_cnt
    );

    modport slave (
        input  req, ack1, ack2,
        output gnt1_idx, gnt1_valid, gnt2_idx, gnt2_valid, gnt_onehot, busy_cnt
    );
endinterface

// File: rtl/dual_grant_arbiter.sv
// rtl/dual_grant_arbiter.sv - registered two-slot request arbiter, fixed or round-robin priority
//
// Purpose: picks up to two distinct requesters from bus.req and holds each
// winner in a grant slot until the consumer acks that slot.
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst_n  synchronous reset, active low
//   bus    slave side of dual_grant_arbiter_if (req, ack1/2 in; grants out)
module dual_grant_arbiter #(
    parameter int  N           = 4,
    parameter int  ROUND_ROBIN = 0,
    localparam int IW          = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    dual_grant_arbiter_if.slave bus
);

    logic [IW-1:0] gnt1_idx_q, gnt1_idx_d;
    logic [IW-1:0] gnt2_idx_q, gnt2_idx_d;
    logic          gnt1_valid_q, gnt1_valid_d;
    logic          gnt2_valid_q, gnt2_valid_d;
    logic [N-1:0]  onehot_q, onehot_d;
    logic [1:0]    busy_q, busy_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic          ack1_eff, ack2_eff;
    logic          free1, free2;
    logic          held1, held2;
    logic [N-1:0]  held_mask;
    logic [N-1:0]  elig;
    logic          hit1_found, hit2_found;
    logic [IW-1:0] hit1_idx, hit2_idx;

    // Decrement modulo N; N need not be a power of two, so 0 wraps to N-1.
    function automatic logic [IW-1:0] dec_mod(input logic [IW-1:0] x);
        return (x == '0) ? IW'(N - 1) : x - IW'(1);
    endfunction

    function automatic logic [N-1:0] to_onehot(input logic [IW-1:0] x);
        return N'(1) << x;
    endfunction

    // Acks only count against a slot that actually holds a grant.
    assign ack1_eff = bus.ack1 & gnt1_valid_q;
    assign ack2_eff = bus.ack2 & gnt2_valid_q;
    assign held1    = gnt1_valid_q & ~ack1_eff;
    assign held2    = gnt2_valid_q & ~ack2_eff;
    assign free1    = ~held1;
    assign free2    = ~held2;

    // A held index is invisible to the search so both slots stay distinct.
    assign held_mask = (held1 ? to_onehot(gnt1_idx_q) : '0)
                     | (held2 ? to_onehot(gnt2_idx_q) : '0);
    assign elig      = bus.req & ~held_mask;

    // The search starts from the pointer value that will be stored this edge;
    // slot 2's ack takes precedence so the just-served slot-2 index goes last.
    always_comb begin
        ptr_d = IW'(N - 1);
        if (ROUND_ROBIN != 0) begin
            if (ack2_eff)      ptr_d = dec_mod(gnt2_idx_q);
            else if (ack1_eff) ptr_d = dec_mod(gnt1_idx_q);
            else               ptr_d = ptr_q;
        end
    end

    // Walk downward from ptr_d, wrapping mod N, keeping the first two hits.
    always_comb begin
        int            start;
        int            cand;
        logic [IW-1:0] cand_idx;
        hit1_found = 1'b0;
        hit2_found = 1'b0;
        hit1_idx   = '0;
        hit2_idx   = '0;
        start      = int'(ptr_d);
        for (int k = 0; k < N; k++) begin
            cand     = (start >= k) ? (start - k) : (start + N - k);
            cand_idx = IW'(cand);
            if (elig[cand_idx]) begin
                if (!hit1_found) begin
                    hit1_found = 1'b1;
                    hit1_idx   = cand_idx;
                end else if (!hit2_found) begin
                    hit2_found = 1'b1;
                    hit2_idx   = cand_idx;
                end
            end
        end
    end

    // Slot allocation; a slot that finds no hit goes invalid but keeps its idx.
    always_comb begin
        gnt1_valid_d = gnt1_valid_q;
        gnt1_idx_d   = gnt1_idx_q;
        gnt2_valid_d = gnt2_valid_q;
        gnt2_idx_d   = gnt2_idx_q;
        if (free1 && free2) begin
            gnt1_valid_d = hit1_found;
            if (hit1_found) gnt1_idx_d = hit1_idx;
            gnt2_valid_d = hit2_found;
            if (hit2_found) gnt2_idx_d = hit2_idx;
        end else if (free1) begin
            gnt1_valid_d = hit1_found;
            if (hit1_found) gnt1_idx_d = hit1_idx;
        end else if (free2) begin
            gnt2_valid_d = hit1_found;
            if (hit1_found) gnt2_idx_d = hit1_idx;
        end
        onehot_d = (gnt1_valid_d ? to_onehot(gnt1_idx_d) : '0)
                 | (gnt2_valid_d ? to_onehot(gnt2_idx_d) : '0);
        busy_d   = {1'b0, gnt1_valid_d} + {1'b0, gnt2_valid_d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt1_valid_q <= 1'b0;
            gnt1_idx_q   <= '0;
            gnt2_valid_q <= 1'b0;
            gnt2_idx_q   <= '0;
            onehot_q     <= '0;
            busy_q       <= '0;
            ptr_q        <= IW'(N - 1);
        end else begin
            gnt1_valid_q <= gnt1_valid_d;
            gnt1_idx_q   <= gnt1_idx_d;
            gnt2_valid_q <= gnt2_valid_d;
            gnt2_idx_q   <= gnt2_idx_d;
            onehot_q     <= onehot_d;
            busy_q       <= busy_d;
            ptr_q        <= ptr_d;
        end
    end

    assign bus.gnt1_idx   = gnt1_idx_q;
    assign bus.gnt1_valid = gnt1_valid_q;
    assign bus.gnt2_idx   = gnt2_idx_q;
    assign bus.gnt2_valid = gnt2_valid_q;
    assign bus.gnt_onehot = onehot_q;
    assign bus.busy_cnt   = busy_q;

endmodule

// File: tb/tb_dual_grant_arbiter.sv
// tb/tb_dual_grant_arbiter.sv - self-checking bench for dual_grant_arbiter
module tb_dual_grant_arbiter;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    logic [31:0] sb[$];

    typedef struct {
        int rq;
        int a1;
        int a2;
        int v1;
        int i1;
        int v2;
        int i2;
    } step_t;

    dual_grant_arbiter_if #(.N(4)) if_fix ();
    dual_grant_arbiter_if #(.N(4)) if_rr4 ();
    dual_grant_arbiter_if #(.N(5)) if_rr5 ();

    dual_grant_arbiter #(.N(4), .ROUND_ROBIN(0)) u_fix (.clk(clk), .rst_n(rst_n), .bus(if_fix));
    dual_grant_arbiter #(.N(4), .ROUND_ROBIN(1)) u_rr4 (.clk(clk), .rst_n(rst_n), .bus(if_rr4));
    dual_grant_arbiter #(.N(5), .ROUND_ROBIN(1)) u_rr5 (.clk(clk), .rst_n(rst_n), .bus(if_rr5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Expected snapshot: {v1, idx1, v2, idx2, onehot, busy}, onehot/busy derived here.
    function automatic logic [31:0] mk(input int v1, input int i1, input int v2, input int i2);
        logic [7:0] oh;
        logic [1:0] busy;
        oh = '0;
        if (v1 != 0) oh[i1] = 1'b1;
        if (v2 != 0) oh[i2] = 1'b1;
        busy = 2'(v1 + v2);
        return {14'd0, 1'(v1), 3'(i1), 1'(v2), 3'(i2), oh, busy};
    endfunction

    function automatic logic [31:0] snap_fix();
        return {14'd0, if_fix.gnt1_valid, 1'b0, if_fix.gnt1_idx, if_fix.gnt2_valid, 1'b0,
                if_fix.gnt2_idx, 4'd0, if_fix.gnt_onehot, if_fix.busy_cnt};
    endfunction

    function automatic logic [31:0] snap_rr4();
        return {14'd0, if_rr4.gnt1_valid, 1'b0, if_rr4.gnt1_idx, if_rr4.gnt2_valid, 1'b0,
                if_rr4.gnt2_idx, 4'd0, if_rr4.gnt_onehot, if_rr4.busy_cnt};
    endfunction

    function automatic logic [31:0] snap_rr5();
        return {14'd0, if_rr5.gnt1_valid, if_rr5.gnt1_idx, if_rr5.gnt2_valid,
                if_rr5.gnt2_idx, 3'd0, if_rr5.gnt_onehot, if_rr5.busy_cnt};
    endfunction

    task automatic idle_all();
        if_fix.req = '0; if_fix.ack1 = 1'b0; if_fix.ack2 = 1'b0;
        if_rr4.req = '0; if_rr4.ack1 = 1'b0; if_rr4.ack2 = 1'b0;
        if_rr5.req = '0; if_rr5.ack1 = 1'b0; if_rr5.ack2 = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] exp, got;
        idle_all();
        if_fix.req = 4'b1111;
        if_rr5.req = 5'b11111;
        rst_n = 1'b0;
        sb.push_back(mk(0, 0, 0, 0));
        sb.push_back(mk(0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        exp = sb.pop_front(); got = snap_fix(); tests++;
        if (got !== exp) begin failed++; $display("FAIL reset_fix got=%h exp=%h", got, exp); end
        exp = sb.pop_front(); got = snap_rr5(); tests++;
        if (got !== exp) begin failed++; $display("FAIL reset_rr5 got=%h exp=%h", got, exp); end

        rst_n = 1'b1;
        sb.push_back(mk(1, 3, 1, 2));
        @(posedge clk); #1;
        exp = sb.pop_front(); got = snap_fix(); tests++;
        if (got !== exp) begin failed++; $display("FAIL reset_first_grant got=%h exp=%h", got, exp); end

        rst_n = 1'b0;
        sb.push_back(mk(0, 0, 0, 0));
        @(posedge clk); #1;
        exp = sb.pop_front(); got = snap_fix(); tests++;
        if (got !== exp) begin failed++; $display("FAIL reset_mid_hold got=%h exp=%h", got, exp); end
        rst_n = 1'b1;
        idle_all();
    endtask

    task automatic test_fixed();
        step_t st[$];
        logic [31:0] exp, got;
        do_reset();
        st.push_back('{32'b1011, 0, 0, 1, 3, 1, 1});
        st.push_back('{32'b1111, 0, 1, 1, 3, 1, 2});
        st.push_back('{32'b1111, 0, 0, 1, 3, 1, 2});
        st.push_back('{32'b0000, 0, 0, 1, 3, 1, 2});
        st.push_back('{32'b0000, 1, 0, 0, 3, 1, 2});
        st.push_back('{32'b0100, 0, 1, 1, 2, 0, 2});
        st.push_back('{32'b0100, 0, 1, 1, 2, 0, 2});
        st.push_back('{32'b0000, 1, 0, 0, 2, 0, 2});
        st.push_back('{32'b1000, 0, 0, 1, 3, 0, 2});
        st.push_back('{32'b1000, 1, 0, 1, 3, 0, 2});
        st.push_back('{32'b0000, 1, 1, 0, 3, 0, 2});
        foreach (st[k]) begin
            if_fix.req  = 4'(st[k].rq);
            if_fix.ack1 = 1'(st[k].a1);
            if_fix.ack2 = 1'(st[k].a2);
            sb.push_back(mk(st[k].v1, st[k].i1, st[k].v2, st[k].i2));
            @(posedge clk); #1;
            exp = sb.pop_front(); got = snap_fix(); tests++;
            if (got !== exp) begin failed++; $display("FAIL fixed step %0d got=%h exp=%h", k, got, exp); end
        end
        idle_all();
    endtask

    task automatic test_rr_fair();
        step_t st[$];
        int cnt[4];
        logic [31:0] exp, got;
        do_reset();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int k = 0; k < 8; k++) begin
            if_rr4.req = 4'b1111; if_rr4.ack1 = 1'b1; if_rr4.ack2 = 1'b1;
            if (k % 2 == 0) sb.push_back(mk(1, 3, 1, 2));
            else            sb.push_back(mk(1, 1, 1, 0));
            @(posedge clk); #1;
            exp = sb.pop_front(); got = snap_rr4(); tests++;
            if (got !== exp) begin failed++; $display("FAIL rr_pairs step %0d got=%h exp=%h", k, got, exp); end
            if (if_rr4.gnt1_valid) cnt[if_rr4.gnt1_idx]++;
            if (if_rr4.gnt2_valid) cnt[if_rr4.gnt2_idx]++;
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (cnt[i] != 4) begin failed++; $display("FAIL rr_fair idx %0d got=%0d exp=4", i, cnt[i]); end
        end
        st.push_back('{32'b1111, 1, 1, 1, 3, 1, 2});
        st.push_back('{32'b1111, 1, 0, 1, 1, 1, 2});
        st.push_back('{32'b1111, 0, 1, 1, 1, 1, 0});
        foreach (st[k]) begin
            if_rr4.req  = 4'(st[k].rq);
            if_rr4.ack1 = 1'(st[k].a1);
            if_rr4.ack2 = 1'(st[k].a2);
            sb.push_back(mk(st[k].v1, st[k].i1, st[k].v2, st[k].i2));
            @(posedge clk); #1;
            exp = sb.pop_front(); got = snap_rr4(); tests++;
            if (got !== exp) begin failed++; $display("FAIL rr_single_ack step %0d got=%h exp=%h", k, got, exp); end
        end
        idle_all();
    endtask

    task automatic test_rr_wrap();
        step_t st[$];
        logic [31:0] exp, got;
        do_reset();
        for (int k = 0; k < 4; k++) st.push_back('{32'b10001, 1, 1, 1, 4, 1, 0});
        st.push_back('{32'b01010, 1, 1, 1, 3, 1, 1});
        st.push_back('{32'b00111, 1, 1, 1, 0, 1, 2});
        st.push_back('{32'b00111, 1, 1, 1, 1, 1, 0});
        st.push_back('{32'b00111, 1, 1, 1, 2, 1, 1});
        st.push_back('{32'b00000, 1, 1, 0, 2, 0, 1});
        foreach (st[k]) begin
            if_rr5.req  = 5'(st[k].rq);
            if_rr5.ack1 = 1'(st[k].a1);
            if_rr5.ack2 = 1'(st[k].a2);
            sb.push_back(mk(st[k].v1, st[k].i1, st[k].v2, st[k].i2));
            @(posedge clk); #1;
            exp = sb.pop_front(); got = snap_rr5(); tests++;
            if (got !== exp) begin failed++; $display("FAIL rr_wrap step %0d got=%h exp=%h", k, got, exp); end
        end
        idle_all();
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        idle_all();
        @(posedge clk); #1;
        test_reset();
        test_fixed();
        test_rr_fair();
        test_rr_wrap();
        tests++;
        if (sb.size() != 0) begin failed++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
